// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one line-wide data-memory port between two cache masters:
//   master 0 = instruction-cache refill, master 1 = data-cache miss/write-back.
// The winning request is latched in IDLE and drives the memory for exactly one
// transaction. The memory acknowledge is forwarded combinationally to the
// owner. A single DONE cycle follows every transaction so that masters can
// drop their enables before the port is re-arbitrated.
//
// Handshake: a master raises mX_enable_i with write/addr/data stable and holds
// it until mX_ack_o pulses for one cycle. Toward memory, mem_enable_o stays
// high until mem_ack_i is seen. mem_ack_i outside a transaction is ignored.
//
// Optional feature: define DMEM_ARB_RR_EN for round-robin tie breaking
// (grant the master not granted last; first tie after reset goes to master 0).
// Without it, master 1 wins every tie.
//
// Ports:
//   clk_i, rst_i              clock (rising edge), async active-high reset
//   mX_enable_i/_write_i      request and direction (1 = line write)
//   mX_addr_i/_data_i         byte address (bits [4:0] ignored), write line
//   mX_data_o/_ack_o          read line (zero unless granted), one-cycle ack
//   mem_*_o / mem_*_i         shared memory port, mem_addr_o bits [4:0] = 0
//   grant_o                   one-hot owner {m1,m0}, 00 when idle
//   state_o                   debug: FSM state (0 IDLE, 1 BUSY0, 2 BUSY1, 3 DONE)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Clears the byte-within-line bits; masking on capture keeps every address
  // input bit in use and the low register bits constant zero.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(5'h1f);

  state_t              state_q, state_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                any_req;
  logic                winner;   // 1 = master 1 wins this arbitration

  assign any_req = m0_enable_i | m1_enable_i;

`ifdef DMEM_ARB_RR_EN
  logic last_q, last_d;   // master granted most recently

  always_comb begin
    winner = m1_enable_i;
    if (m0_enable_i && m1_enable_i) winner = ~last_q;
  end

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && any_req) last_d = winner;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= 1'b1;   // so the first tie goes to master 0
    else       last_q <= last_d;
  end
`else
  // Fixed priority: master 1 wins ties, otherwise the lone requester wins.
  assign winner = m1_enable_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    data_d       = data_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    m0_ack_o     = 1'b0;
    m1_ack_o     = 1'b0;
    m0_data_o    = '0;
    m1_data_o    = '0;
    grant_o      = 2'b00;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = winner ? BUSY1 : BUSY0;
          wr_d    = winner ? m1_write_i : m0_write_i;
          addr_d  = (winner ? m1_addr_i : m0_addr_i) & LINE_MASK;
          data_d  = winner ? m1_data_i : m0_data_i;
        end
      end
      BUSY0: begin
        mem_enable_o = 1'b1;
        mem_write_o  = wr_q;
        mem_addr_o   = addr_q;
        mem_data_o   = data_q;
        grant_o      = 2'b01;
        m0_ack_o     = mem_ack_i;
        m0_data_o    = mem_data_i;
        if (mem_ack_i) state_d = DONE;
      end
      BUSY1: begin
        mem_enable_o = 1'b1;
        mem_write_o  = wr_q;
        mem_addr_o   = addr_q;
        mem_data_o   = data_q;
        grant_o      = 2'b10;
        m1_ack_o     = mem_ack_i;
        m1_data_o    = mem_data_i;
        if (mem_ack_i) state_d = DONE;
      end
      DONE: begin
        // Turnaround: port released, masters get one cycle to drop enable.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter: self-checking bench for dmem_arbiter.
// Table-driven single transactions, hand-written multi-cycle sequences
// (ties, write-back then refill, spurious ack, reset mid-transaction) and a
// randomized phase; every cycle is compared against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          m0_en, m0_wr, m1_en, m1_wr;
  logic [AW-1:0] m0_ad, m1_ad;
  logic [DW-1:0] m0_wd, m1_wd, m0_rd, m1_rd;
  logic          m0_ack, m1_ack;
  logic          mem_en, mem_wr, mem_ack;
  logic [AW-1:0] mem_ad;
  logic [DW-1:0] mem_wd, mem_rd;
  logic [1:0]    grant, state;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_enable_i(m0_en), .m0_write_i(m0_wr), .m0_addr_i(m0_ad), .m0_data_i(m0_wd),
    .m0_data_o(m0_rd), .m0_ack_o(m0_ack),
    .m1_enable_i(m1_en), .m1_write_i(m1_wr), .m1_addr_i(m1_ad), .m1_data_i(m1_wd),
    .m1_data_o(m1_rd), .m1_ack_o(m1_ack),
    .mem_enable_o(mem_en), .mem_write_o(mem_wr), .mem_addr_o(mem_ad),
    .mem_data_o(mem_wd), .mem_data_i(mem_rd), .mem_ack_i(mem_ack),
    .grant_o(grant), .state_o(state)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: -1 = port free, 0/1 = master holding the port.
  // gap: one turnaround cycle after a completed transaction.
  int            own = -1;
  bit            gap = 1'b0;
  int            last = 1;
  logic          l_wr;
  logic [AW-1:0] l_ad;
  logic [DW-1:0] l_wd;
  bit            got_ack[2];
  logic [AW-1:0] exp_q[$];   // addresses of granted transactions, in order
  logic          prev_en = 1'b0;

  task automatic model_check();
    bit busy;
    busy = !rst && own >= 0;
    chk("mem_enable", mem_en, busy);
    chk("mem_write", mem_wr, busy ? l_wr : 1'b0);
    chk("mem_addr", mem_ad, busy ? l_ad : '0);
    chk("mem_data", mem_wd, busy ? l_wd : '0);
    chk("grant", grant, !busy ? 2'b00 : (own == 1 ? 2'b10 : 2'b01));
    got_ack[0] = busy && own == 0 && mem_ack;
    got_ack[1] = busy && own == 1 && mem_ack;
    chk("m0_ack", m0_ack, got_ack[0]);
    chk("m1_ack", m1_ack, got_ack[1]);
    chk("m0_data", m0_rd, (busy && own == 0) ? mem_rd : '0);
    chk("m1_data", m1_rd, (busy && own == 1) ? mem_rd : '0);
    if (mem_en && !prev_en) begin
      chk("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) chk("sb_addr", mem_ad, exp_q.pop_front());
    end
    prev_en = mem_en;
  endtask

  task automatic model_update();
    int w;
    if (rst) begin
      own = -1; gap = 1'b0; last = 1; exp_q.delete(); prev_en = 1'b0;
    end else if (own >= 0) begin
      if (mem_ack) begin own = -1; gap = 1'b1; end
    end else if (gap) begin
      gap = 1'b0;
    end else if (m0_en || m1_en) begin
      if (m0_en && m1_en) begin
`ifdef DMEM_ARB_RR_EN
        w = 1 - last;
`else
        w = 1;
`endif
      end else begin
        w = m1_en ? 1 : 0;
      end
      last = w;
      own  = w;
      l_wr = (w == 1) ? m1_wr : m0_wr;
      l_ad = ((w == 1) ? m1_ad : m0_ad) & ~32'h1f;
      l_wd = (w == 1) ? m1_wd : m0_wd;
      exp_q.push_back(l_ad);
    end
  endtask

  // One clock: compare at the falling edge, advance model, return at posedge+1.
  task automatic step();
    @(negedge clk);
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(int m, logic en, logic wr, logic [AW-1:0] ad, logic [DW-1:0] wd);
    if (m == 0) begin m0_en = en; m0_wr = wr; m0_ad = ad; m0_wd = wd; end
    else        begin m1_en = en; m1_wr = wr; m1_ad = ad; m1_wd = wd; end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1; mem_ack = 1'b0; mem_rd = '0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    step();
    step();
    rst = 1'b0;
  endtask

  // Waits (bounded) for a grant, holds the memory for lat cycles, then acks.
  // Returns in the DONE cycle.
  task automatic serve(int lat, output logic [1:0] g);
    int n;
    n = 0;
    while (grant == 2'b00 && n < 8) begin step(); n++; end
    chk("grant_wait", grant != 2'b00, 1'b1);
    g = grant;
    repeat (lat) step();
    mem_rd = rand_line(); mem_ack = 1'b1;
    #1;
    chk("serve_ack", {m1_ack, m0_ack}, g);
    step();
    mem_ack = 1'b0;
  endtask

  // ---------------- random stimulus ----------------
  int mem_cnt = -1;

  task automatic drive_random();
    bit en;
    if (own >= 0) begin
      if (mem_cnt < 0) mem_cnt = $urandom_range(0, 4);
      mem_ack = (mem_cnt == 0);
      if (mem_cnt == 0) mem_cnt = -1; else mem_cnt--;
    end else begin
      mem_ack = ($urandom_range(0, 9) == 0);
      mem_cnt = -1;
    end
    mem_rd = rand_line();
    for (int m = 0; m < 2; m++) begin
      en = (m == 0) ? m0_en : m1_en;
      if (got_ack[m]) begin
        if ($urandom_range(0, 1) == 1) set_req(m, 1'b1, 1'($urandom), $urandom, rand_line());
        else                           set_req(m, 1'b0, 1'b0, '0, '0);
      end else if (en) begin
        if ($urandom_range(0, 19) == 0)     set_req(m, 1'b0, 1'b0, '0, '0);
        else if ($urandom_range(0, 4) == 0) set_req(m, 1'b1, 1'($urandom), $urandom, rand_line());
      end else if ($urandom_range(0, 2) == 0) begin
        set_req(m, 1'b1, 1'($urandom), $urandom, rand_line());
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int            m;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    int            lat;
    logic [AW-1:0] exp_addr;
    logic [1:0]    exp_grant;
  } vec_t;

  vec_t       vt[4];
  logic [1:0] tie_exp[4];
  logic [1:0] g;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0, 1'b0, 32'h0000_0420, {8{32'h0BAD_F00D}}, {32{8'hA5}}, 3, 32'h0000_0420, 2'b01};
    vt[1] = '{1, 1'b1, 32'h0000_043C, {8{32'h1234_5678}}, {8{32'hDEAD_BEEF}}, 2, 32'h0000_0420, 2'b10};
    vt[2] = '{0, 1'b1, 32'hFFFF_FFFF, {4{64'h0123_4567_89AB_CDEF}}, {16{16'h5A5A}}, 0, 32'hFFFF_FFE0, 2'b01};
    vt[3] = '{1, 1'b0, 32'h0000_001F, '0, {64{4'h3}}, 1, 32'h0000_0000, 2'b10};
`ifdef DMEM_ARB_RR_EN
    tie_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    tie_exp = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif

    do_reset();
    chk("reset_state", state, 2'd0);
    chk("reset_enable", mem_en, 1'b0);

    // Single transactions from the table.
    for (int i = 0; i < 4; i++) begin
      set_req(vt[i].m, 1'b1, vt[i].wr, vt[i].addr, vt[i].wd);
      step();
      #1;
      chk("v_grant", grant, vt[i].exp_grant);
      chk("v_addr", mem_ad, vt[i].exp_addr);
      chk("v_write", mem_wr, vt[i].wr);
      chk("v_wdata", mem_wd, vt[i].wd);
      repeat (vt[i].lat) step();
      mem_rd = vt[i].rd; mem_ack = 1'b1;
      #1;
      chk("v_ack", {m1_ack, m0_ack}, vt[i].exp_grant);
      chk("v_rdata", (vt[i].m == 1) ? m1_rd : m0_rd, vt[i].rd);
      chk("v_other_data", (vt[i].m == 1) ? m0_rd : m1_rd, '0);
      step();
      mem_ack = 1'b0;
      set_req(vt[i].m, 1'b0, 1'b0, '0, '0);
      #1;
      chk("v_done_enable", mem_en, 1'b0);
      chk("v_done_grant", grant, 2'b00);
      step();
    end

    // Simultaneous requests held for four rounds, then m1 withdraws.
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h0000_5000, '0);
    set_req(1, 1'b1, 1'b0, 32'h0000_6000, '0);
    for (int r = 0; r < 4; r++) begin
      serve(1, g);
      chk("tie_round", g, tie_exp[r]);
    end
    set_req(1, 1'b0, 1'b0, '0, '0);
    serve(0, g);
    chk("tie_after_m1_drop", g, 2'b01);
    set_req(0, 1'b0, 1'b0, '0, '0);
    step();

    // Write-back then refill from m1 with enable held across the ack.
    do_reset();
    set_req(1, 1'b1, 1'b1, 32'h0000_1000, {8{32'hCAFE_0001}});
    serve(2, g);
    chk("wb_grant", g, 2'b10);
    set_req(1, 1'b1, 1'b0, 32'h0000_2000, '0);
    #1;
    chk("wb_done_enable", mem_en, 1'b0);
    chk("wb_done_grant", grant, 2'b00);
    step();
    chk("wb_idle_grant", grant, 2'b00);
    step();
    chk("refill_grant", grant, 2'b10);
    chk("refill_addr", mem_ad, 32'h0000_2000);
    chk("refill_write", mem_wr, 1'b0);
    serve(1, g);
    set_req(1, 1'b0, 1'b0, '0, '0);
    step();

    // Spurious ack while idle, then input changes and enable drop during BUSY0.
    mem_ack = 1'b1;
    repeat (3) begin
      step();
      chk("spur_ack", {m1_ack, m0_ack}, 2'b00);
      chk("spur_state", state, 2'd0);
    end
    mem_ack = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h0000_3000, {8{32'h0000_3000}});
    step();
    #1;
    chk("busy0_grant", grant, 2'b01);
    set_req(0, 1'b1, 1'b1, 32'h0000_3FE0, {8{32'hFFFF_0000}});
    step();
    chk("busy0_addr_held", mem_ad, 32'h0000_3000);
    chk("busy0_write_held", mem_wr, 1'b0);
    set_req(0, 1'b0, 1'b0, '0, '0);
    step();
    chk("busy0_no_abort", mem_en, 1'b1);
    serve(0, g);
    chk("busy0_owner", g, 2'b01);
    step();

    // Reset in BUSY1 with a simultaneous memory ack.
    set_req(1, 1'b1, 1'b0, 32'h0000_7000, '0);
    step();
    #1;
    chk("rst_pre_grant", grant, 2'b10);
    step();
    rst = 1'b1; mem_ack = 1'b1;
    #1;
    chk("rst_enable", mem_en, 1'b0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_ack", m1_ack, 1'b0);
    chk("rst_addr", mem_ad, '0);
    chk("rst_state", state, 2'd0);
    step();
    rst = 1'b0; mem_ack = 1'b0;
    step();
    #1;
    chk("rst_rearb_grant", grant, 2'b10);
    serve(1, g);
    set_req(1, 1'b0, 1'b0, '0, '0);
    step();

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      step();
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    mem_ack = 1'b0;
    repeat (8) begin
      mem_ack = (own >= 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
